// File: rtl/ezm_host_pkg.sv
// Shared types and widths for the EZM host: FSM states, clock slots, word sizes.
package ezm_host_pkg;

  localparam int WORD_W = 6;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  localparam logic [WORD_W-1:0] NOP_WORD = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPURST = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SL_L0 = 2'd0,
    SL_L1 = 2'd1,
    SL_H0 = 2'd2,
    SL_H1 = 2'd3
  } slot_t;

  function automatic slot_t next_slot(input slot_t s);
    return slot_t'(s + 2'd1);
  endfunction

  // Generated CPU clock level for a given slot: high during H0/H1.
  function automatic logic clk_level(input slot_t s);
    return (s == SL_H0) || (s == SL_H1);
  endfunction

endpackage

// File: rtl/ezm_host_prog_mem.sv
// Program store for the EZM host: synchronous write, combinational read (old word on same-cycle collision).
module ezm_prog_mem
  import ezm_host_pkg::*;
#(
  parameter int MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < MEM_DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ezm_host.sv
// EZM host: loads a program, clocks and resets an external CPU, and captures its multiplexed acc/pc bus.
// The slot sequencer is four slots per CPU period, so PERIOD is expected to stay at 4.
module ezm_host
  import ezm_host_pkg::*;
#(
  parameter int MEM_DEPTH = 32,
  parameter int PERIOD    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic [WORD_W-1:0] prog_len,
  input  logic [DATA_W-1:0] step_limit,
  input  logic              start,
  input  logic [DATA_W-1:0] cpu_out_i,
  output logic              cpu_clk_o,
  output logic              cpu_rst_o,
  output logic [WORD_W-1:0] instr_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] pc_o,
  output logic              acc_valid,
  output logic              pc_valid,
  output logic              busy,
  output logic              halted
);

  localparam int RST_CYCLES = 2 * PERIOD;
  localparam int RC_W       = $clog2(RST_CYCLES);
  localparam logic [RC_W-1:0]   RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [DATA_W:0]   MEM_LIM  = (DATA_W + 1)'(MEM_DEPTH);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + DATA_W'(1);
  endfunction

  state_t            state;
  slot_t             slot;
  slot_t             slot_nxt;
  logic              p;
  logic [RC_W-1:0]   rst_cnt;
  logic [DATA_W-1:0] step_cnt;
  logic [DATA_W-1:0] step_nxt;
  logic              range_hit;
  logic              limit_hit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_raddr;
  logic [WORD_W-1:0] mem_rdata;

  // Memory is only writable while the CPU is parked; in RUN the read port follows the captured pc.
  assign mem_we    = prog_we && ((state == ST_IDLE) || (state == ST_HALT));
  assign mem_raddr = (state == ST_RUN) ? cpu_out_i[ADDR_W-1:0] : '0;

  ezm_prog_mem #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign slot_nxt  = next_slot(slot);
  assign step_nxt  = sat_inc(step_cnt);
  assign range_hit = (cpu_out_i >= {{(DATA_W-WORD_W){1'b0}}, prog_len}) ||
                     ({1'b0, cpu_out_i} >= MEM_LIM);
  assign limit_hit = (step_limit != '0) && (step_nxt == step_limit);

  assign busy   = (state == ST_CPURST) || (state == ST_RUN);
  assign halted = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      slot      <= SL_L0;
      p         <= 1'b0;
      rst_cnt   <= '0;
      step_cnt  <= '0;
      cpu_clk_o <= 1'b0;
      cpu_rst_o <= 1'b1;
      instr_o   <= NOP_WORD;
      acc_o     <= '0;
      pc_o      <= '0;
      acc_valid <= 1'b0;
      pc_valid  <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      pc_valid  <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: begin
          cpu_clk_o <= 1'b0;
          cpu_rst_o <= 1'b1;
          slot      <= SL_L0;
          if (start) begin
            state    <= ST_CPURST;
            rst_cnt  <= '0;
            p        <= 1'b0;
            step_cnt <= '0;
            pc_o     <= '0;
            instr_o  <= mem_rdata;
          end
        end
        ST_CPURST: begin
          slot      <= slot_nxt;
          cpu_clk_o <= clk_level(slot_nxt);
          rst_cnt   <= rst_cnt + RC_W'(1);
          if (rst_cnt == RST_LAST) begin
            state     <= ST_RUN;
            cpu_rst_o <= 1'b0;
          end
        end
        ST_RUN: begin
          slot      <= slot_nxt;
          cpu_clk_o <= clk_level(slot_nxt);
          if (slot == SL_L1) begin
            p <= ~p;
          end
          // L0 sits just before the next rising edge: capture the bus and, on pc phases, fetch.
          if (slot == SL_L0) begin
            if (!p) begin
              acc_o     <= cpu_out_i;
              acc_valid <= 1'b1;
            end else begin
              pc_o     <= cpu_out_i;
              pc_valid <= 1'b1;
              step_cnt <= step_nxt;
              instr_o  <= range_hit ? NOP_WORD : mem_rdata;
              if (range_hit || limit_hit) begin
                state     <= ST_HALT;
                cpu_rst_o <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ezm_host.sv
// Directed bench for ezm_host with a small accumulator-CPU model and an acc/pc scoreboard.
module tb_ezm_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_we = 1'b0;
  logic [4:0] prog_addr = '0;
  logic [5:0] prog_data = '0;
  logic [5:0] prog_len = '0;
  logic [7:0] step_limit = '0;
  logic       start = 1'b0;
  logic [7:0] cpu_out_i;
  logic       cpu_clk_o, cpu_rst_o;
  logic [5:0] instr_o;
  logic [7:0] acc_o, pc_o;
  logic       acc_valid, pc_valid, busy, halted;

  ezm_host #(.MEM_DEPTH(32), .PERIOD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_len   (prog_len),
    .step_limit (step_limit),
    .start      (start),
    .cpu_out_i  (cpu_out_i),
    .cpu_clk_o  (cpu_clk_o),
    .cpu_rst_o  (cpu_rst_o),
    .instr_o    (instr_o),
    .acc_o      (acc_o),
    .pc_o       (pc_o),
    .acc_valid  (acc_valid),
    .pc_valid   (pc_valid),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // CPU model: executes on every other rising edge, bus shows acc (q=0) or pc (q=1).
  // ISA on instr[5:3]: 100 load imm3, 001 add imm3, 000 with instr[0]=1 invert, else nop.
  logic [7:0] m_acc = '0;
  logic [7:0] m_pc = '0;
  logic       m_q = 1'b0;
  logic       force_en = 1'b0;

  always @(posedge cpu_clk_o or posedge cpu_rst_o) begin
    if (cpu_rst_o) begin
      m_acc <= '0;
      m_pc  <= '0;
      m_q   <= 1'b0;
    end else begin
      m_q <= ~m_q;
      if (!m_q) begin
        m_pc <= m_pc + 8'd1;
        case (instr_o[5:3])
          3'b100:  m_acc <= {5'd0, instr_o[2:0]};
          3'b001:  m_acc <= m_acc + {5'd0, instr_o[2:0]};
          3'b000:  if (instr_o[0]) m_acc <= ~m_acc;
          default: ;
        endcase
      end
    end
  end

  assign cpu_out_i = m_q ? (force_en ? 8'h40 : m_pc) : m_acc;

  int         vectors = 0;
  int         miscompares = 0;
  int         acc_cnt = 0;
  int         pc_cnt = 0;
  logic       sb_on = 1'b0;
  logic       prev_clk = 1'b0;
  logic       in_h1 = 1'b0;
  logic [7:0] exp_acc[$];
  logic [7:0] exp_pc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    check("valid_excl", 32'(acc_valid & pc_valid), 32'd0);
    if (acc_valid) begin
      acc_cnt++;
      if (sb_on) begin
        if (exp_acc.size() == 0) check("acc_extra", 32'(acc_valid), 32'd0);
        else begin
          e = exp_acc.pop_front();
          check("acc_o", 32'(acc_o), 32'(e));
        end
      end
    end
    if (pc_valid) begin
      pc_cnt++;
      if (sb_on) begin
        if (exp_pc.size() == 0) check("pc_extra", 32'(pc_valid), 32'd0);
        else begin
          e = exp_pc.pop_front();
          check("pc_o", 32'(pc_o), 32'(e));
        end
      end
    end
    in_h1    = cpu_clk_o && prev_clk;
    prev_clk = cpu_clk_o;
  endtask

  task automatic write_word(input logic [4:0] a, input logic [5:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic push_prog_expect();
    exp_acc.push_back(8'h00);
    exp_acc.push_back(8'h05);
    exp_acc.push_back(8'hFA);
    exp_pc.push_back(8'd1);
    exp_pc.push_back(8'd2);
    exp_pc.push_back(8'd3);
  endtask

  initial begin
    int   rst_cyc = 0;
    int   entries = 0;
    int   hi = 0;
    logic prev_in = 1'b0;
    logic cur;
    logic wrote = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("rst_cpu_clk", 32'(cpu_clk_o), 32'd0);
    check("rst_instr", 32'(instr_o), 32'd0);
    check("rst_acc", 32'(acc_o), 32'd0);
    check("rst_pc", 32'(pc_o), 32'd0);
    rst = 1'b0;

    // Three-word program, start held 3 cycles, write attempt during RUN
    write_word(5'd0, 6'b100101);
    write_word(5'd1, 6'b000001);
    write_word(5'd2, 6'b001011);
    prog_len   = 6'd3;
    step_limit = 8'd0;
    push_prog_expect();
    sb_on   = 1'b1;
    acc_cnt = 0;
    pc_cnt  = 0;
    start   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 0) check("cpurst_instr", 32'(instr_o), 32'h25);
      if (i == 2) start = 1'b0;
      cur = busy && cpu_rst_o;
      if (cur) rst_cyc++;
      if (cur && !prev_in) entries++;
      prev_in = cur;
      if (busy && !cpu_rst_o && !wrote) begin
        prog_we   = 1'b1;
        prog_addr = 5'd0;
        prog_data = 6'h3F;
        wrote     = 1'b1;
      end else begin
        prog_we = 1'b0;
      end
      if (halted) break;
    end
    prog_we = 1'b0;
    check("run1_halted", 32'(halted), 32'd1);
    check("cpurst_cycles", 32'(rst_cyc), 32'd8);
    check("cpurst_entries", 32'(entries), 32'd1);
    check("run1_pc_final", 32'(pc_o), 32'd3);
    check("run1_acc_final", 32'(acc_o), 32'hFA);
    check("run1_instr_nop", 32'(instr_o), 32'd0);
    check("halt_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("halt_cpu_clk", 32'(cpu_clk_o), 32'd0);
    check("run1_pc_pulses", 32'(pc_cnt), 32'd3);
    check("run1_acc_pulses", 32'(acc_cnt), 32'd3);
    check("run1_acc_left", 32'(exp_acc.size()), 32'd0);
    check("run1_pc_left", 32'(exp_pc.size()), 32'd0);

    // RUN-time write ignored; reset in slot H1 mid-run
    push_prog_expect();
    start_run();
    check("run_write_ignored", 32'(instr_o), 32'h25);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pc_cnt >= 1 && busy && !cpu_rst_o && in_h1) break;
    end
    check("h1_found", 32'(in_h1 && busy && !cpu_rst_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_halted", 32'(halted), 32'd0);
    check("midrun_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("midrun_cpu_clk", 32'(cpu_clk_o), 32'd0);
    check("midrun_acc", 32'(acc_o), 32'd0);
    check("midrun_pc", 32'(pc_o), 32'd0);
    check("midrun_instr", 32'(instr_o), 32'd0);
    exp_acc.delete();
    exp_pc.delete();

    // Readback run: memory survived rst
    push_prog_expect();
    start_run();
    check("readback_instr", 32'(instr_o), 32'h25);
    run_to_halt("readback", 300);
    check("readback_pc", 32'(pc_o), 32'd3);
    check("readback_acc_left", 32'(exp_acc.size()), 32'd0);
    check("readback_pc_left", 32'(exp_pc.size()), 32'd0);
    sb_on = 1'b0;

    // Write in HALT takes effect
    write_word(5'd0, 6'h3F);
    start_run();
    check("halt_write_instr", 32'(instr_o), 32'h3F);
    run_to_halt("nop_prog", 300);
    write_word(5'd0, 6'b100101);

    // Step limit of 4
    prog_len   = 6'd32;
    step_limit = 8'd4;
    pc_cnt     = 0;
    start_run();
    run_to_halt("limit", 400);
    check("limit_pc_pulses", 32'(pc_cnt), 32'd4);
    check("limit_pc", 32'(pc_o), 32'd4);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpu_clk_o) hi++;
    end
    check("limit_clk_low", 32'(hi), 32'd0);
    check("limit_still_halted", 32'(halted), 32'd1);
    check("limit_pc_hold", 32'(pc_o), 32'd4);

    // Out-of-range pc on the bus
    step_limit = 8'd0;
    force_en   = 1'b1;
    pc_cnt     = 0;
    start_run();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pc_cnt > 0) break;
    end
    force_en = 1'b0;
    check("oor_pc_pulse", 32'(pc_valid), 32'd1);
    check("oor_halted", 32'(halted), 32'd1);
    check("oor_instr", 32'(instr_o), 32'd0);
    check("oor_pc", 32'(pc_o), 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ezm_host.md
EZM_HOST -- requirements
Module: ezm_host

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MEM_DEPTH, 32, program words held.
- PERIOD, 4, host clk cycles per generated CPU clock period.
REQ-002 Ports (name direction width meaning), one per line:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- prog_we in 1: program write strobe.
- prog_addr in 5: program write address.
- prog_data in 6: program instruction word.
- prog_len in 6: words in program; a fetched pc >= prog_len ends the run.
- step_limit in 8: maximum executed steps; 0 = unlimited.
- start in 1: single-cycle run request.
- cpu_out_i in 8: multiplexed CPU output bus (acc in phase 0, pc in phase 1).
- cpu_clk_o out 1: generated CPU clock.
- cpu_rst_o out 1: CPU reset.
- instr_o out 6: instruction word presented to the CPU.
- acc_o out 8: last captured accumulator.
- pc_o out 8: last captured pc.
- acc_valid out 1: one-cycle pulse on acc_o update.
- pc_valid out 1: one-cycle pulse on pc_o update.
- busy out 1: high in CPURST and RUN.
- halted out 1: high in HALT.

Function
REQ-003 States SHALL be IDLE, CPURST, RUN, HALT.
REQ-004 IDLE/HALT + start=1 SHALL enter CPURST next cycle; start SHALL be ignored in CPURST/RUN.
REQ-005 Each CPU period SHALL be slots L0,L1,H0,H1; cpu_clk_o SHALL be registered, low in L0/L1 and high in H0/H1.
REQ-006 CPURST SHALL last 2 periods (8 cycles) with cpu_rst_o=1 and cpu_clk_o toggling; step counter, phase bit and pc_o SHALL clear to 0; instr_o SHALL be mem[0] from its first cycle; it SHALL then enter RUN at slot L0.
REQ-007 In RUN, cpu_rst_o=0; phase bit p SHALL toggle at every H0 (rising CPU edge); p=0 after CPURST.
REQ-008 In every RUN L0 with p=0, acc_o SHALL load cpu_out_i and acc_valid SHALL pulse.
REQ-009 In every RUN L0 with p=1, pc_o SHALL load cpu_out_i, pc_valid SHALL pulse, step counter SHALL increment (8-bit, saturating at 255), and instr_o SHALL load mem[cpu_out_i[4:0]] (valid in L1, before the next rising edge).
REQ-010 If in that L0 cpu_out_i >= prog_len (8-bit compare, prog_len zero-extended) or cpu_out_i >= MEM_DEPTH, instr_o SHALL load 6'b000000 and the FSM SHALL enter HALT.
REQ-011 If step_limit != 0 and the incremented count equals step_limit, the FSM SHALL enter HALT; range halt and limit halt in the same L0 SHALL give a single HALT entry.
REQ-012 In HALT, cpu_clk_o SHALL stay low, acc_o/pc_o/instr_o SHALL hold, and halted=1.
REQ-013 Program writes (mem[prog_addr] <= prog_data) SHALL take effect only in IDLE/HALT; prog_we SHALL be ignored in CPURST/RUN.
REQ-014 Program reads SHALL be combinational; a write and a read of the same address in one cycle SHALL return the old word.
REQ-015 acc_valid and pc_valid SHALL never be high simultaneously.

Reset
REQ-016 rst SHALL force IDLE, slot L0, p=0, cpu_clk_o=0, cpu_rst_o=1, instr_o=0, acc_o=0, pc_o=0, step counter=0, all pulses/flags 0 on the next clk edge, including mid-RUN.
REQ-017 Program memory SHALL NOT be cleared by rst.
REQ-018 cpu_rst_o SHALL remain 1 in IDLE and HALT.

Structure
REQ-019 Package ezm_host_pkg SHALL hold the state enum, slot enum, NOP word 6'b000000, word/address widths.
REQ-020 Storage SHALL be sub-module ezm_prog_mem (MEM_DEPTH x 6, sync write, async read); FSM, slot counter and capture registers SHALL reside in ezm_host.

Verification
REQ-021 Load mem[0..2]={6'b100101,6'b000001,6'b001011}, prog_len=3, start; CPU model -> acc_o sequence 0x05,0xFA, pc_o 1,2,3, HALT after pc=3, instr_o=0.
REQ-022 prog_len=32, step_limit=4, CPU model -> exactly 4 pc_valid pulses, halted=1, cpu_clk_o low thereafter.
REQ-023 cpu_out_i forced to 0x40 during p=1 L0 -> instr_o=0, HALT next cycle.
REQ-024 rst asserted in RUN slot H1 -> next cycle IDLE, cpu_rst_o=1, acc_o=pc_o=0; mem contents unchanged on readback run.
REQ-025 prog_we in RUN to addr 0 with 6'h3F -> mem[0] unchanged; same write in HALT -> mem[0]=6'h3F.
REQ-026 start held 3 cycles in IDLE -> single CPURST of exactly 8 cycles, cpu_rst_o=1 throughout.
